// File: rtl/epp_regfile_if.sv
// EPP host handshake signals shared between the host side and the register file.
// The 8-bit data bus stays a plain inout port on the register file so that
// tri-state resolution happens on an ordinary net.
interface epp_regfile_if;
    logic EppAstb;
    logic EppDstb;
    logic EppWr;
    logic EppWait;

    modport master (
        output EppAstb,
        output EppDstb,
        output EppWr,
        input  EppWait
    );

    modport slave (
        input  EppAstb,
        input  EppDstb,
        input  EppWr,
        output EppWait
    );
endinterface

// File: rtl/epp_regfile.sv
// EPP slave register file: an address register plus NUM_REGS 8-bit registers,
// reached through asynchronous EPP address/data strobes that are synchronized
// to clk and acknowledged through EppWait.
module epp_regfile #(
    parameter int          NUM_REGS    = 16,
    parameter int          SYNC_STAGES = 2,
    parameter int          AUTO_INC    = 1,
    parameter logic [7:0]  RESET_VAL   = 8'h00
) (
    input  logic                    clk,
    input  logic                    reset,
    epp_regfile_if.slave            epp,
    inout  wire  [7:0]              EppDB,
    output logic [NUM_REGS*8-1:0]   reg_q,
    output logic                    wr_stb,
    output logic [7:0]              wr_addr,
    output logic                    rd_stb
);

    localparam int         AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] NUM_REGS_W  = 9'(NUM_REGS);
    localparam logic [7:0] LAST_ADDR   = 8'(NUM_REGS - 1);
    localparam bit         AUTO_INC_EN = (AUTO_INC != 0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] astb_sync_r;
    logic [SYNC_STAGES-1:0] dstb_sync_r;
    logic                   astb_s;
    logic                   dstb_s;

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] addr_r;
    logic [7:0] addr_next_s;
    logic [7:0] addr_inc_s;
    logic [7:0] rdata_r;
    logic [7:0] rdata_next_s;
    logic       is_read_r;
    logic       is_read_next_s;
    logic       reg_we_s;
    logic       wr_stb_next_s;
    logic       rd_stb_next_s;
    logic       wait_r;
    logic       drive_r;
    logic       wr_stb_r;
    logic       rd_stb_r;
    logic [7:0] wr_addr_r;

    logic [7:0]    regs_r [NUM_REGS];
    logic          in_range_s;
    logic [AW-1:0] idx_s;
    logic [7:0]    db_in_s;
    logic [7:0]    reg_rd_s;

    assign astb_s     = astb_sync_r[SYNC_STAGES-1];
    assign dstb_s     = dstb_sync_r[SYNC_STAGES-1];
    assign db_in_s    = EppDB;
    assign in_range_s = ({1'b0, addr_r} < NUM_REGS_W);
    assign idx_s      = addr_r[AW-1:0];

    assign EppDB       = drive_r ? rdata_r : 8'hzz;
    assign epp.EppWait = wait_r;
    assign wr_stb      = wr_stb_r;
    assign rd_stb      = rd_stb_r;
    assign wr_addr     = wr_addr_r;

    // Strobe synchronizers; reset to the idle (high) level.
    always_ff @(posedge clk) begin
        if (reset) begin
            astb_sync_r <= '1;
            dstb_sync_r <= '1;
        end else begin
            astb_sync_r <= {astb_sync_r[SYNC_STAGES-2:0], epp.EppAstb};
            dstb_sync_r <= {dstb_sync_r[SYNC_STAGES-2:0], epp.EppDstb};
        end
    end

    // Read mux: out-of-range addresses read as zero.
    always_comb begin
        reg_rd_s = 8'h00;
        if (in_range_s) begin
            reg_rd_s = regs_r[idx_s];
        end else begin
            reg_rd_s = 8'h00;
        end
    end

    // Auto-increment target, wrapping from the last register back to 0.
    always_comb begin
        addr_inc_s = addr_r;
        if (addr_r == LAST_ADDR) begin
            addr_inc_s = 8'h00;
        end else begin
            addr_inc_s = addr_r + 8'h01;
        end
    end

    // Next-state and cycle decode; the address strobe wins over the data strobe.
    always_comb begin
        state_next_s   = state_r;
        addr_next_s    = addr_r;
        rdata_next_s   = rdata_r;
        is_read_next_s = is_read_r;
        reg_we_s       = 1'b0;
        wr_stb_next_s  = 1'b0;
        rd_stb_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!astb_s) begin
                    is_read_next_s = epp.EppWr;
                    state_next_s   = ACK;
                    if (epp.EppWr) begin
                        rdata_next_s = addr_r;
                    end else begin
                        addr_next_s = db_in_s;
                    end
                end else if (!dstb_s) begin
                    is_read_next_s = epp.EppWr;
                    state_next_s   = ACK;
                    if (epp.EppWr) begin
                        rdata_next_s  = reg_rd_s;
                        rd_stb_next_s = in_range_s;
                    end else begin
                        reg_we_s      = in_range_s;
                        wr_stb_next_s = in_range_s;
                    end
                    if (AUTO_INC_EN && in_range_s) begin
                        addr_next_s = addr_inc_s;
                    end else begin
                        addr_next_s = addr_r;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACK: begin
                if (astb_s && dstb_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ACK;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Control state, handshake outputs and pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            addr_r    <= 8'h00;
            rdata_r   <= 8'h00;
            is_read_r <= 1'b0;
            wait_r    <= 1'b0;
            drive_r   <= 1'b0;
            wr_stb_r  <= 1'b0;
            rd_stb_r  <= 1'b0;
            wr_addr_r <= 8'h00;
        end else begin
            state_r   <= state_next_s;
            addr_r    <= addr_next_s;
            rdata_r   <= rdata_next_s;
            is_read_r <= is_read_next_s;
            wait_r    <= (state_next_s == ACK);
            drive_r   <= (state_next_s == ACK) && is_read_next_s;
            wr_stb_r  <= wr_stb_next_s;
            rd_stb_r  <= rd_stb_next_s;
            if (wr_stb_next_s) begin
                wr_addr_r <= addr_r;
            end else begin
                wr_addr_r <= wr_addr_r;
            end
        end
    end

    // Register array; written on the edge that leaves IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VAL;
            end
        end else if (reg_we_s) begin
            regs_r[idx_s] <= db_in_s;
        end
    end

    // Flatten the register array onto reg_q.
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*8 +: 8] = regs_r[i];
        end
    end

endmodule

// File: tb/tb_epp_regfile.sv
// Directed bench: a 16-register and a 4-register instance run in lockstep from
// the same host strobes, each on its own data bus.
module tb_epp_regfile;

    logic clk = 1'b0;
    logic reset;
    logic astb_d;
    logic dstb_d;
    logic wr_d;
    logic host_oe;
    logic [7:0] host_db;

    epp_regfile_if bus16 ();
    epp_regfile_if bus4 ();
    wire [7:0] db16;
    wire [7:0] db4;

    logic [127:0] reg_q16;
    logic [31:0]  reg_q4;
    logic         wr_stb16, rd_stb16, wr_stb4, rd_stb4;
    logic [7:0]   wr_addr16, wr_addr4;

    assign bus16.EppAstb = astb_d;
    assign bus16.EppDstb = dstb_d;
    assign bus16.EppWr   = wr_d;
    assign bus4.EppAstb  = astb_d;
    assign bus4.EppDstb  = dstb_d;
    assign bus4.EppWr    = wr_d;
    assign db16 = host_oe ? host_db : 8'hzz;
    assign db4  = host_oe ? host_db : 8'hzz;

    epp_regfile dut16 (
        .clk(clk), .reset(reset), .epp(bus16.slave), .EppDB(db16),
        .reg_q(reg_q16), .wr_stb(wr_stb16), .wr_addr(wr_addr16), .rd_stb(rd_stb16)
    );

    epp_regfile #(.NUM_REGS(4)) dut4 (
        .clk(clk), .reset(reset), .epp(bus4.slave), .EppDB(db4),
        .reg_q(reg_q4), .wr_stb(wr_stb4), .wr_addr(wr_addr4), .rd_stb(rd_stb4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt16 = 0, rd_cnt16 = 0, wr_cnt4 = 0, rd_cnt4 = 0, both_cnt = 0;
    logic [7:0] last_wa16 = 8'h00;

    // Pulse monitors.
    always @(posedge clk) begin
        if (wr_stb16) begin
            wr_cnt16  <= wr_cnt16 + 1;
            last_wa16 <= wr_addr16;
        end
        if (rd_stb16) rd_cnt16 <= rd_cnt16 + 1;
        if (wr_stb4)  wr_cnt4  <= wr_cnt4 + 1;
        if (rd_stb4)  rd_cnt4  <= rd_cnt4 + 1;
        if ((wr_stb16 && rd_stb16) || (wr_stb4 && rd_stb4)) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One complete host cycle on both instances; returns read data from each bus.
    task automatic host_cycle(input logic is_addr, input logic is_read, input logic [7:0] wval,
                              output logic [7:0] r16, output logic [7:0] r4);
        int n;
        wr_d    = is_read;
        host_db = wval;
        host_oe = !is_read;
        if (is_addr) astb_d = 1'b0;
        else         dstb_d = 1'b0;
        n = 0;
        while (!(bus16.EppWait && bus4.EppWait) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ack_seen", {127'b0, bus16.EppWait & bus4.EppWait}, 128'd1);
        r16 = db16;
        r4  = db4;
        astb_d = 1'b1;
        dstb_d = 1'b1;
        n = 0;
        while ((bus16.EppWait || bus4.EppWait) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ack_released", {127'b0, bus16.EppWait | bus4.EppWait}, 128'd0);
        host_oe = 1'b1;
        host_db = 8'h00;
        @(negedge clk);
    endtask

    logic [7:0]   r16, r4;
    logic [127:0] exp16;
    int           wr0_16, rd0_16, wr0_4, rd0_4, n, held;

    initial begin
        reset = 1'b1; astb_d = 1'b1; dstb_d = 1'b1; wr_d = 1'b0;
        host_oe = 1'b1; host_db = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_wait16", {127'b0, bus16.EppWait}, 128'd0);
        chk("rst_regs16", reg_q16, 128'd0);
        chk("rst_regs4", {96'b0, reg_q4}, 128'd0);
        chk("rst_bus_released", {120'b0, db16}, 128'h00);
        host_cycle(1'b1, 1'b1, 8'h00, r16, r4);
        chk("rst_addr", {112'b0, r16, r4}, 128'h0000);

        // Write 0xAA to register 1 then read it back
        host_cycle(1'b1, 1'b0, 8'h01, r16, r4);
        host_cycle(1'b0, 1'b0, 8'hAA, r16, r4);
        host_cycle(1'b1, 1'b0, 8'h01, r16, r4);
        host_cycle(1'b0, 1'b1, 8'h00, r16, r4);
        chk("rd_reg1", {112'b0, r16, r4}, 128'hAAAA);
        chk("reg_q16_byte1", {120'b0, reg_q16[15:8]}, 128'hAA);
        chk("wr_cnt_first", {96'b0, wr_cnt16}, 128'd1);
        chk("wr_addr_first", {120'b0, last_wa16}, 128'h01);
        chk("rd_cnt_first", {96'b0, rd_cnt16}, 128'd1);
        chk("bus_released_after_read", {112'b0, db16, db4}, 128'h0000);
        host_cycle(1'b1, 1'b1, 8'h00, r16, r4);
        chk("addr_after_read_inc", {112'b0, r16, r4}, 128'h0202);

        // Auto-increment and wrap on the 4-register instance
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
        host_cycle(1'b1, 1'b0, 8'h03, r16, r4);
        host_cycle(1'b0, 1'b0, 8'h11, r16, r4);
        host_cycle(1'b0, 1'b0, 8'h22, r16, r4);
        chk("wrap_regs4", {96'b0, reg_q4}, {96'b0, 32'h11000022});
        exp16 = 128'd0;
        exp16[31:24] = 8'h11;
        exp16[39:32] = 8'h22;
        chk("inc_regs16", reg_q16, exp16);
        host_cycle(1'b1, 1'b1, 8'h00, r16, r4);
        chk("wrap_addr", {112'b0, r16, r4}, 128'h0501);

        // Out-of-range address: writes discarded, reads zero, no increment
        wr0_16 = wr_cnt16; rd0_16 = rd_cnt16; wr0_4 = wr_cnt4; rd0_4 = rd_cnt4;
        host_cycle(1'b1, 1'b0, 8'h20, r16, r4);
        host_cycle(1'b0, 1'b0, 8'h55, r16, r4);
        host_cycle(1'b0, 1'b1, 8'h00, r16, r4);
        chk("oor_read", {112'b0, r16, r4}, 128'h0000);
        chk("oor_no_strobes", {64'b0, wr_cnt16 - wr0_16, rd_cnt16 - rd0_16},
            128'd0);
        chk("oor_no_strobes4", {64'b0, wr_cnt4 - wr0_4, rd_cnt4 - rd0_4}, 128'd0);
        chk("oor_regs16", reg_q16, exp16);
        chk("oor_regs4", {96'b0, reg_q4}, {96'b0, 32'h11000022});
        host_cycle(1'b1, 1'b1, 8'h00, r16, r4);
        chk("oor_addr", {112'b0, r16, r4}, 128'h2020);

        // Data strobe held low for 100 cycles
        host_cycle(1'b1, 1'b0, 8'h00, r16, r4);
        wr0_16 = wr_cnt16; wr0_4 = wr_cnt4;
        wr_d = 1'b0; host_db = 8'h66; dstb_d = 1'b0;
        n = 0;
        while (!bus16.EppWait && n < 40) begin
            @(negedge clk);
            n++;
        end
        held = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus16.EppWait && bus4.EppWait) held++;
        end
        chk("hold_wait_high", {96'b0, held}, 128'd100);
        dstb_d = 1'b1;
        n = 0;
        while (bus16.EppWait && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hold_release_latency_ok", {127'b0, (n <= 3)}, 128'd1);
        host_db = 8'h00;
        @(negedge clk);
        chk("hold_one_wr", {64'b0, wr_cnt16 - wr0_16, wr_cnt4 - wr0_4},
            {64'b0, 32'd1, 32'd1});
        exp16[7:0] = 8'h66;
        chk("hold_regs16", reg_q16, exp16);
        chk("hold_regs4", {96'b0, reg_q4}, {96'b0, 32'h11000066});

        // Both strobes together: address cycle wins
        wr0_16 = wr_cnt16;
        wr_d = 1'b0; host_db = 8'h07; astb_d = 1'b0; dstb_d = 1'b0;
        n = 0;
        while (!bus16.EppWait && n < 40) begin
            @(negedge clk);
            n++;
        end
        astb_d = 1'b1; dstb_d = 1'b1;
        repeat (6) @(negedge clk);
        host_db = 8'h00;
        chk("both_no_write", {96'b0, wr_cnt16 - wr0_16}, 128'd0);
        chk("both_regs16", reg_q16, exp16);
        host_cycle(1'b1, 1'b1, 8'h00, r16, r4);
        chk("both_addr", {112'b0, r16, r4}, 128'h0707);

        // Reset during a read acknowledge
        host_cycle(1'b1, 1'b0, 8'h01, r16, r4);
        host_cycle(1'b0, 1'b0, 8'h5A, r16, r4);
        host_cycle(1'b1, 1'b0, 8'h01, r16, r4);
        wr_d = 1'b1; host_oe = 1'b0; dstb_d = 1'b0;
        n = 0;
        while (!bus16.EppWait && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_read_data", {120'b0, db16}, 128'h5A);
        reset = 1'b1; host_oe = 1'b1; host_db = 8'h00;
        @(negedge clk);
        chk("rst_mid_wait", {126'b0, bus16.EppWait, bus4.EppWait}, 128'd0);
        chk("rst_mid_bus", {112'b0, db16, db4}, 128'h0000);
        chk("rst_mid_regs16", reg_q16, 128'd0);
        chk("rst_mid_regs4", {96'b0, reg_q4}, 128'd0);
        rd0_16 = rd_cnt16;
        reset = 1'b0; host_oe = 1'b0;
        n = 0;
        while (!bus16.EppWait && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst_restart_ack", {127'b0, bus16.EppWait}, 128'd1);
        @(negedge clk);
        chk("rst_restart_rd", {96'b0, rd_cnt16 - rd0_16}, 128'd1);
        dstb_d = 1'b1;
        repeat (6) @(negedge clk);
        host_oe = 1'b1;
        chk("rst_restart_released", {127'b0, bus16.EppWait}, 128'd0);

        chk("no_wr_rd_overlap", {96'b0, both_cnt}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/epp_regfile.md
EPP_REGFILE -- requirements
Module: epp_regfile

Interface
- REQ-001: Parameter NUM_REGS, default 16, number of host-accessible 8-bit registers (legal range 1..256).
- REQ-002: Parameter SYNC_STAGES, default 2, flip-flop stages on each EPP strobe input (legal range 2..4).
- REQ-003: Parameter AUTO_INC, default 1, nonzero enables address auto-increment after every data cycle.
- REQ-004: Parameter RESET_VAL, default 8'h00, reset value of every register.
- REQ-005: clk  input  1  single system clock; all logic on its rising edge.
- REQ-006: reset  input  1  synchronous, active-high reset.
- REQ-007: EppAstb  input  1  host address strobe, active low, asynchronous to clk.
- REQ-008: EppDstb  input  1  host data strobe, active low, asynchronous to clk.
- REQ-009: EppWr  input  1  host direction; 0 = host write, 1 = host read.
- REQ-010: EppDB  inout  8  bidirectional EPP data bus; high-Z unless the block drives a read.
- REQ-011: EppWait  output  1  handshake acknowledge; 1 = cycle accepted, host may release strobe.
- REQ-012: reg_q  output  NUM_REGS*8  flat register contents; register n occupies bits [8n+7:8n].
- REQ-013: wr_stb  output  1  one-cycle pulse on every register write.
- REQ-014: wr_addr  output  8  register index written; valid while wr_stb=1.
- REQ-015: rd_stb  output  1  one-cycle pulse on every data read of an in-range register.

Function
- REQ-016: EppAstb and EppDstb SHALL each pass through SYNC_STAGES flops before use; EppWr and EppDB SHALL be sampled only when a synchronized strobe is low.
- REQ-017: FSM states: IDLE, ACK; transitions only on clk edge.
- REQ-018: IDLE, synchronized Astb low: EppWr=0 loads address register from EppDB; EppWr=1 loads read-data register with current address; go to ACK.
- REQ-019: IDLE, synchronized Dstb low (Astb high), EppWr=0: address < NUM_REGS writes EppDB into that register, pulses wr_stb with wr_addr; address >= NUM_REGS discards data, no wr_stb; go to ACK.
- REQ-020: IDLE, synchronized Dstb low (Astb high), EppWr=1: read-data register loads addressed register (8'h00 if address >= NUM_REGS); rd_stb pulses only if in range; go to ACK.
- REQ-021: Both synchronized strobes low in IDLE: address cycle SHALL take priority; data cycle ignored.
- REQ-022: EppWait SHALL be 1 exactly while state is ACK; first asserted the cycle after the triggering IDLE edge.
- REQ-023: During ACK of a read cycle, EppDB SHALL be driven with the read-data register; high-Z otherwise.
- REQ-024: ACK -> IDLE when both synchronized strobes are high; EppWait and the EppDB driver release on the same edge.
- REQ-025: A register write SHALL update reg_q on the edge that leaves IDLE (visible the following cycle).
- REQ-026: AUTO_INC nonzero: after each data cycle with address < NUM_REGS, address increments; NUM_REGS-1 wraps to 0; out-of-range address never increments. Address cycles never increment.
- REQ-027: AUTO_INC = 0: address register changes only on address-write cycles.
- REQ-028: Strobe low held indefinitely SHALL cause exactly one cycle; a new cycle requires return to IDLE first.
- REQ-029: wr_stb and rd_stb SHALL never assert in the same cycle.

Reset
- REQ-030: reset=1 at a clk edge: state IDLE, EppWait=0, EppDB high-Z, address 8'h00, all registers RESET_VAL, wr_stb=rd_stb=0, read-data 8'h00, synchronizers set to 1 (idle).
- REQ-031: Reset mid-cycle aborts it; strobes still low after reset deassertion SHALL start a new cycle from IDLE.

Verification
- REQ-032: Address write 8'h01, data write 8'hAA, address write 8'h01, data read -> EppDB=8'hAA while EppWait=1; reg_q[15:8]=8'hAA; one wr_stb with wr_addr=1.
- REQ-033: AUTO_INC=1, NUM_REGS=4: address 8'h03, write 8'h11, 8'h22 -> reg3=8'h11, reg0=8'h22, address reads back 8'h01.
- REQ-034: Address 8'h20 with NUM_REGS=16, write 8'h55 then read -> no wr_stb, no rd_stb, read returns 8'h00, all registers unchanged, address stays 8'h20.
- REQ-035: Dstb held low 100 cycles -> exactly one wr_stb, EppWait=1 throughout, drops within SYNC_STAGES+1 cycles of Dstb release.
- REQ-036: Astb and Dstb lowered together with EppDB=8'h07 -> address becomes 8'h07, no register write.
- REQ-037: reset asserted during read ACK -> EppWait=0 and EppDB high-Z next cycle, all registers equal RESET_VAL.
